// File: rtl/time_set_controller.sv
// rtl/time_set_controller.sv - time-setting sequencer: key debounce, RUN/SET_* FSM, inc/dec strobes, blink, timeout
module time_set_controller #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int DEB_CYC    = 1_000_000,
    parameter int REP_DLY    = 25_000_000,
    parameter int REP_PER    = 5_000_000,
    parameter int BLINK_HALF = 12_500_000,
    parameter int TIMEOUT_S  = 10
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_sel,
    input  logic       key_up,
    input  logic       key_down,
    output logic       set_mode,
    output logic [2:0] field_sel,
    output logic       inc_p,
    output logic       dec_p,
    output logic       blink
);

    localparam int DEB_W   = $clog2(DEB_CYC + 1);
    localparam int REP_MAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam int BLK_W   = $clog2(BLINK_HALF + 1);
    localparam int PS_W    = $clog2(CLK_HZ + 1);
    localparam int SEC_W   = $clog2(TIMEOUT_S + 1);

    localparam int K_MODE = 0;
    localparam int K_SEL  = 1;
    localparam int K_UP   = 2;
    localparam int K_DOWN = 3;

    typedef enum logic [1:0] {ST_RUN, ST_SEC, ST_MIN, ST_HR} state_t;

    state_t                 state_q, state_d;
    logic [3:0]             key_raw;
    logic [3:0]             sync1_q, sync2_q;
    logic [3:0]             lvl_q, lvl_d, lvl_prev_q;
    logic [3:0][DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [3:0]             press;

    logic                   held_up, held_dn, one_held;
    logic                   timeout;
    logic                   in_set_stay, in_set_both;
    logic                   ev_inc, ev_dec, rep_run, rep_hit, fire_inc, fire_dec;

    logic                   rep_arm_q, rep_arm_d;
    logic                   rep_first_q, rep_first_d;
    logic [REP_W-1:0]       rep_cnt_q, rep_cnt_d;
    logic [PS_W-1:0]        ps_q, ps_d;
    logic [SEC_W-1:0]       sec_q, sec_d;
    logic [BLK_W-1:0]       blk_cnt_q, blk_cnt_d;
    logic                   blink_q, blink_d;
    logic                   set_mode_q;
    logic [2:0]             field_q, field_d;
    logic                   inc_q, dec_q;

    assign key_raw = {key_down, key_up, key_sel, key_mode};

    // Per-key debounce: level flips after DEB_CYC consecutive differing synced samples
    always_comb begin
        lvl_d     = lvl_q;
        deb_cnt_d = '0;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] != lvl_q[i]) begin
                if (deb_cnt_q[i] == DEB_W'(DEB_CYC - 1)) begin
                    lvl_d[i] = ~lvl_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
                end
            end
        end
    end

    assign press    = lvl_prev_q & ~lvl_q;
    assign held_up  = ~lvl_q[K_UP];
    assign held_dn  = ~lvl_q[K_DOWN];
    assign one_held = held_up ^ held_dn;

    // A press in the same cycle as the terminal count wins over the timeout
    assign timeout = (state_q != ST_RUN) && (ps_q == PS_W'(CLK_HZ - 1)) &&
                     (sec_q == SEC_W'(TIMEOUT_S - 1)) && !(|press);

    // Next-state logic; mode beats sel when both fire together
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (press[K_MODE]) state_d = ST_SEC;
            end
            default: begin
                if (press[K_MODE] || timeout) begin
                    state_d = ST_RUN;
                end else if (press[K_SEL]) begin
                    case (state_q)
                        ST_SEC:  state_d = ST_MIN;
                        ST_MIN:  state_d = ST_HR;
                        default: state_d = ST_SEC;
                    endcase
                end
            end
        endcase
    end

    assign in_set_both = (state_q != ST_RUN) && (state_d != ST_RUN);
    assign in_set_stay = (state_q != ST_RUN) && (state_d == state_q);
    assign ev_inc      = press[K_UP]   & ~held_dn & in_set_both;
    assign ev_dec      = press[K_DOWN] & ~held_up & in_set_both;
    assign rep_run     = rep_arm_q & one_held & in_set_stay;
    assign rep_hit     = rep_run && (rep_cnt_q == (rep_first_q ? REP_W'(REP_DLY) : REP_W'(REP_PER)));
    assign fire_inc    = ev_inc | (rep_hit & held_up);
    assign fire_dec    = ev_dec | (rep_hit & held_dn);

    // Auto-repeat: armed by an up/down event, held at zero while both keys are down
    always_comb begin
        rep_arm_d   = rep_arm_q;
        rep_first_d = rep_first_q;
        rep_cnt_d   = rep_cnt_q;
        if (!in_set_stay || !(held_up | held_dn)) begin
            rep_arm_d   = 1'b0;
            rep_first_d = 1'b1;
            rep_cnt_d   = '0;
        end else if (ev_inc | ev_dec) begin
            rep_arm_d   = 1'b1;
            rep_first_d = 1'b1;
            rep_cnt_d   = REP_W'(1);
        end else if (rep_hit) begin
            rep_first_d = 1'b0;
            rep_cnt_d   = REP_W'(1);
        end else if (rep_run) begin
            rep_cnt_d   = rep_cnt_q + REP_W'(1);
        end else begin
            rep_first_d = 1'b1;
            rep_cnt_d   = '0;
        end
    end

    // Inactivity timer: seconds prescaler restarted by any press or strobe
    always_comb begin
        ps_d  = ps_q;
        sec_d = sec_q;
        if ((state_q == ST_RUN) || (|press) || fire_inc || fire_dec) begin
            ps_d  = '0;
            sec_d = '0;
        end else if (ps_q == PS_W'(CLK_HZ - 1)) begin
            ps_d = '0;
            if (sec_q != SEC_W'(TIMEOUT_S)) sec_d = sec_q + SEC_W'(1);
        end else begin
            ps_d = ps_q + PS_W'(1);
        end
    end

    // Blink phase restarts visible on entry, field change and every strobe
    always_comb begin
        blink_d   = blink_q;
        blk_cnt_d = blk_cnt_q;
        if ((state_d == ST_RUN) || (state_d != state_q) || fire_inc || fire_dec) begin
            blink_d   = 1'b1;
            blk_cnt_d = '0;
        end else if (blk_cnt_q == BLK_W'(BLINK_HALF - 1)) begin
            blink_d   = ~blink_q;
            blk_cnt_d = '0;
        end else begin
            blk_cnt_d = blk_cnt_q + BLK_W'(1);
        end
    end

    // One-hot field decode of the next state
    always_comb begin
        field_d = 3'b000;
        case (state_d)
            ST_SEC:  field_d = 3'b001;
            ST_MIN:  field_d = 3'b010;
            ST_HR:   field_d = 3'b100;
            default: field_d = 3'b000;
        endcase
    end

    // State, input path and registered outputs
    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            sync1_q     <= 4'hF;
            sync2_q     <= 4'hF;
            lvl_q       <= 4'hF;
            lvl_prev_q  <= 4'hF;
            deb_cnt_q   <= '0;
            rep_arm_q   <= 1'b0;
            rep_first_q <= 1'b1;
            rep_cnt_q   <= '0;
            ps_q        <= '0;
            sec_q       <= '0;
            blk_cnt_q   <= '0;
            blink_q     <= 1'b1;
            set_mode_q  <= 1'b0;
            field_q     <= 3'b000;
            inc_q       <= 1'b0;
            dec_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= key_raw;
            sync2_q     <= sync1_q;
            lvl_q       <= lvl_d;
            lvl_prev_q  <= lvl_q;
            deb_cnt_q   <= deb_cnt_d;
            rep_arm_q   <= rep_arm_d;
            rep_first_q <= rep_first_d;
            rep_cnt_q   <= rep_cnt_d;
            ps_q        <= ps_d;
            sec_q       <= sec_d;
            blk_cnt_q   <= blk_cnt_d;
            blink_q     <= blink_d;
            set_mode_q  <= (state_d != ST_RUN);
            field_q     <= field_d;
            inc_q       <= fire_inc;
            dec_q       <= fire_dec;
        end
    end

    assign set_mode  = set_mode_q;
    assign field_sel = field_q;
    assign inc_p     = inc_q;
    assign dec_p     = dec_q;
    assign blink     = blink_q;

endmodule

// File: tb/tb_time_set_controller.sv
// tb/tb_time_set_controller.sv - self-checking bench for time_set_controller
module tb_time_set_controller;

    localparam int DEB  = 4;
    localparam int RDLY = 20;
    localparam int RPER = 5;
    localparam int BH   = 8;
    localparam int CHZ  = 10;
    localparam int TOS  = 3;
    // key driven low -> 2 sync flops -> DEB samples -> press -> registered output
    localparam int LAT  = 2 + DEB + 1;
    localparam int TMO  = CHZ * TOS;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] keys_n;   // {down, up, sel, mode}, 0 = pressed
    logic       set_mode, inc_p, dec_p, blink;
    logic [2:0] field_sel;

    int cyc   = 0;
    int tests = 0;
    int fails = 0;
    int exp_inc_q[$];
    int exp_dec_q[$];

    typedef struct packed {
        logic [3:0] press;
        logic       exp_mode;
        logic [2:0] exp_field;
        logic       exp_inc;
        logic       exp_dec;
    } vec_t;

    typedef struct packed {
        logic       m;
        logic [2:0] f;
    } st_t;

    vec_t vecs [13];
    st_t  exp_st_q[$];
    st_t  got;
    int   t, t2, s_hr, e, t_press;

    time_set_controller #(
        .CLK_HZ(CHZ), .DEB_CYC(DEB), .REP_DLY(RDLY), .REP_PER(RPER),
        .BLINK_HALF(BH), .TIMEOUT_S(TOS)
    ) dut (
        .clk_50   (clk),
        .rst_n    (rst_n),
        .key_mode (keys_n[0]),
        .key_sel  (keys_n[1]),
        .key_up   (keys_n[2]),
        .key_down (keys_n[3]),
        .set_mode (set_mode),
        .field_sel(field_sel),
        .inc_p    (inc_p),
        .dec_p    (dec_p),
        .blink    (blink)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic press_key(input logic [3:0] mask, input int hold);
        keys_n  = ~mask;
        t_press = cyc;
        repeat (hold) @(negedge clk);
        keys_n = 4'hF;
        repeat (10) @(negedge clk);
    endtask

    // Strobe scoreboard: each observed pulse must match the oldest expected cycle
    always @(negedge clk) begin : mon
        if (rst_n) begin
            if (inc_p && dec_p) begin
                tests++;
                fails++;
                $display("FAIL both_strobes: inc_p=1 and dec_p=1 at cyc %0d", cyc);
            end
            if (inc_p) begin
                tests++;
                if (exp_inc_q.size() == 0) begin
                    fails++;
                    $display("FAIL inc_unexpected: inc_p=1 at cyc %0d, none expected", cyc);
                end else begin
                    e = exp_inc_q.pop_front();
                    if (e != cyc) begin
                        fails++;
                        $display("FAIL inc_timing: inc_p at cyc %0d expected cyc %0d", cyc, e);
                    end
                end
            end
            if (dec_p) begin
                tests++;
                if (exp_dec_q.size() == 0) begin
                    fails++;
                    $display("FAIL dec_unexpected: dec_p=1 at cyc %0d, none expected", cyc);
                end else begin
                    e = exp_dec_q.pop_front();
                    if (e != cyc) begin
                        fails++;
                        $display("FAIL dec_timing: dec_p at cyc %0d expected cyc %0d", cyc, e);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish (cyc %0d)", cyc);
        $fatal(1);
    end

    initial begin
        // press bits {down, up, sel, mode}
        vecs[0]  = '{4'b0001, 1'b1, 3'b001, 1'b0, 1'b0};
        vecs[1]  = '{4'b0010, 1'b1, 3'b010, 1'b0, 1'b0};
        vecs[2]  = '{4'b0010, 1'b1, 3'b100, 1'b0, 1'b0};
        vecs[3]  = '{4'b0010, 1'b1, 3'b001, 1'b0, 1'b0};
        vecs[4]  = '{4'b0011, 1'b0, 3'b000, 1'b0, 1'b0};
        vecs[5]  = '{4'b0010, 1'b0, 3'b000, 1'b0, 1'b0};
        vecs[6]  = '{4'b0100, 1'b0, 3'b000, 1'b0, 1'b0};
        vecs[7]  = '{4'b0001, 1'b1, 3'b001, 1'b0, 1'b0};
        vecs[8]  = '{4'b1000, 1'b1, 3'b001, 1'b0, 1'b1};
        vecs[9]  = '{4'b0100, 1'b1, 3'b001, 1'b1, 1'b0};
        vecs[10] = '{4'b0101, 1'b0, 3'b000, 1'b0, 1'b0};
        vecs[11] = '{4'b0001, 1'b1, 3'b001, 1'b0, 1'b0};
        vecs[12] = '{4'b0010, 1'b1, 3'b010, 1'b0, 1'b0};

        rst_n  = 1'b0;
        keys_n = 4'hF;
        repeat (3) @(negedge clk);
        check("rst_set_mode", set_mode, 0);
        check("rst_field", field_sel, 0);
        check("rst_inc", inc_p, 0);
        check("rst_dec", dec_p, 0);
        check("rst_blink", blink, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // A 3-cycle glitch is shorter than the debounce window
        keys_n[0] = 1'b0;
        repeat (3) @(negedge clk);
        keys_n[0] = 1'b1;
        repeat (12) @(negedge clk);
        check("bounce_no_mode", set_mode, 0);

        // Stable press: exact entry latency, then blink phase, then idle timeout
        keys_n[0] = 1'b0;
        t = cyc;
        wait_cyc(t + LAT - 1);
        check("mode_before_deb", set_mode, 0);
        wait_cyc(t + LAT);
        check("mode_enter", set_mode, 1);
        check("mode_enter_field", field_sel, 1);
        check("blink_entry", blink, 1);
        wait_cyc(t + LAT + BH - 1);
        check("blink_hold", blink, 1);
        wait_cyc(t + LAT + BH);
        check("blink_off", blink, 0);
        wait_cyc(t + LAT + 2 * BH);
        check("blink_on", blink, 1);
        keys_n[0] = 1'b1;
        wait_cyc(t + LAT + TMO - 1);
        check("sec_before_timeout", set_mode, 1);
        wait_cyc(t + LAT + TMO);
        check("sec_timeout", set_mode, 0);
        check("sec_timeout_field", field_sel, 0);

        // Table: one press per row, state compared after release
        for (int i = 0; i < 13; i++) begin
            keys_n = ~vecs[i].press;
            t = cyc;
            exp_st_q.push_back('{vecs[i].exp_mode, vecs[i].exp_field});
            if (vecs[i].exp_inc) exp_inc_q.push_back(t + LAT);
            if (vecs[i].exp_dec) exp_dec_q.push_back(t + LAT);
            repeat (8) @(negedge clk);
            keys_n = 4'hF;
            repeat (10) @(negedge clk);
            got = exp_st_q.pop_front();
            check($sformatf("tbl%0d_set_mode", i), set_mode, got.m);
            check($sformatf("tbl%0d_field", i), field_sel, got.f);
        end

        // SET_MIN: hold up, first strobe then RDLY, then every RPER until release settles
        t = cyc;
        keys_n[2] = 1'b0;
        e = t + LAT;
        exp_inc_q.push_back(e);
        e = e + RDLY;
        while (e <= t + 45 + 2 + DEB) begin
            exp_inc_q.push_back(e);
            e = e + RPER;
        end
        check("repeat_pulse_count", exp_inc_q.size(), 6);
        wait_cyc(t + 45);
        keys_n[2] = 1'b1;
        wait_cyc(t + 55);

        // up held, down overlaps: repeat held at zero, resumes from zero after down releases
        t = cyc;
        keys_n[2] = 1'b0;
        exp_inc_q.push_back(t + LAT);
        wait_cyc(t + 10);
        keys_n[3] = 1'b0;
        wait_cyc(t + 14);
        keys_n[3] = 1'b1;
        // down level returns high at t+20; counter restarts from zero on the next cycle
        for (int k = 0; k < 4; k++) exp_inc_q.push_back(t + 20 + 1 + RDLY + k * RPER);
        wait_cyc(t + 50);
        keys_n[2] = 1'b1;
        wait_cyc(t + 58);
        check("both_field", field_sel, 3'b010);

        // single down press in SET_MIN
        keys_n[3] = 1'b0;
        t = cyc;
        exp_dec_q.push_back(t + LAT);
        repeat (8) @(negedge clk);
        keys_n[3] = 1'b1;
        repeat (10) @(negedge clk);

        // SET_HR: an up press restarts the idle timeout
        press_key(4'b0010, 8);
        s_hr = t_press + LAT;
        check("hr_field", field_sel, 3'b100);
        wait_cyc(s_hr + 18);
        keys_n[2] = 1'b0;
        t2 = cyc;
        exp_inc_q.push_back(t2 + LAT);
        repeat (8) @(negedge clk);
        keys_n[2] = 1'b1;
        wait_cyc(s_hr + TMO);
        check("hr_timeout_restarted", set_mode, 1);
        wait_cyc(t2 + LAT + TMO - 1);
        check("hr_before_timeout", set_mode, 1);
        wait_cyc(t2 + LAT + TMO);
        check("hr_timeout", set_mode, 0);
        check("hr_timeout_field", field_sel, 0);

        // Reset in SET_MIN with up held: RUN, no strobe after reset released
        press_key(4'b0001, 8);
        press_key(4'b0010, 8);
        check("pre_rst_field", field_sel, 3'b010);
        keys_n[2] = 1'b0;
        t = cyc;
        exp_inc_q.push_back(t + LAT);
        wait_cyc(t + 12);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("midrst_set_mode", set_mode, 0);
        check("midrst_field", field_sel, 0);
        check("midrst_blink", blink, 1);
        check("midrst_inc", inc_p, 0);
        repeat (30) @(negedge clk);
        check("post_rst_run", set_mode, 0);
        keys_n[2] = 1'b1;
        repeat (10) @(negedge clk);

        check("inc_queue_drained", exp_inc_q.size(), 0);
        check("dec_queue_drained", exp_dec_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
